// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: the one writer of the 16x16 register file.
// It merges ALU results and load returns onto a single registered write port.
// ALU results win by default. Load returns wait in a small FIFO and are written
// in ALU-idle cycles. A starvation counter forces a FIFO drain after
// STARVE_LIMIT consecutive ALU wins while loads are waiting.
// Optional feature: define REGFILE_WB_ZERO_LOCK_EN to drop writes to index 0.
// The winner is still consumed, so register 0 stays zero.
//
// Handshakes use strict valid/ready semantics. A transfer happens on a rising
// edge where valid && ready. A producer holding valid without ready must keep
// its payload stable. ready never depends on the valid of the same channel.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_reg,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_W-1:0]          mem_reg,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       RegWrite,
  output logic [ADDR_W-1:0]          WriteReg,
  output logic [DATA_W-1:0]          WriteData,
  output logic [$clog2(DEPTH):0]     mem_pending,
  output logic                       starve_force
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0]  fifo_q [DEPTH];
  logic [ENT_W-1:0]  fifo_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic              empty, full, force_drain, alu_win, pop, push, win, write_en;
  logic [ENT_W-1:0]  win_ent;

  // Arbitration: pick the winner and compute the next FIFO, starvation and output state.
  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == CNT_W'(DEPTH));
    force_drain = (starve_cnt_q == 4'(STARVE_LIMIT)) && !empty;
    alu_win     = alu_valid && !force_drain;
    pop         = !alu_win && !empty;
    // A full FIFO refuses a push even when it pops in the same cycle.
    push        = mem_valid && !full;
    win         = alu_win || pop;
    win_ent     = alu_win ? {alu_reg, alu_data} : fifo_q[rd_ptr_q];

`ifdef REGFILE_WB_ZERO_LOCK_EN
    write_en = win && (win_ent[ENT_W-1 -: ADDR_W] != '0);
`else
    write_en = win;
`endif

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {mem_reg, mem_data};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    starve_cnt_d = starve_cnt_q;
    if (pop || empty) begin
      starve_cnt_d = '0;
    end else if (alu_win && (starve_cnt_q < 4'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    // Index and data only change on a real write, so they hold their last values otherwise.
    reg_write_d  = write_en;
    write_reg_d  = write_en ? win_ent[ENT_W-1 -: ADDR_W] : write_reg_q;
    write_data_d = write_en ? win_ent[DATA_W-1:0]        : write_data_q;
  end

  // State registers. Reset drops queued loads and any write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign alu_ready    = !force_drain;
  assign mem_ready    = !full;
  assign starve_force = force_drain;
  assign mem_pending  = count_q;
  assign RegWrite     = reg_write_q;
  assign WriteReg     = write_reg_q;
  assign WriteData    = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed test-plan scenarios plus random traffic.
// Checks run against a queue-based reference model of the arbitration rules.
module tb_regfile_wb_arbiter;
  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 4;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 3;
  localparam int ENT_W        = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [2:0]        mem_pending;
  logic              starve_force;

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .mem_pending(mem_pending), .starve_force(starve_force)
  );

  // Clock
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [ENT_W-1:0]  load_q[$];   // loads waiting in the FIFO, oldest first
  logic [ENT_W-1:0]  exp_q[$];    // scoreboard of expected register-file writes
  int                starve;
  bit                exp_we;
  logic [ADDR_W-1:0] exp_wreg;
  logic [DATA_W-1:0] exp_wdata;
  bit                alu_pend, mem_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    load_q.delete();
    exp_q.delete();
    starve    = 0;
    exp_we    = 0;
    exp_wreg  = '0;
    exp_wdata = '0;
    alu_pend  = 0;
    mem_pend  = 0;
  endtask

  // Applies one rising edge's worth of the arbitration rules to the model.
  task automatic model_step();
    bit               was_empty, forced, acc, pop, push, wr;
    logic [ENT_W-1:0] w;
    was_empty = (load_q.size() == 0);
    forced    = (starve == STARVE_LIMIT) && !was_empty;
    acc       = alu_valid && !forced;
    pop       = !acc && !was_empty;
    push      = mem_valid && (load_q.size() < DEPTH);
    w         = '0;
    exp_we    = 0;
    if (acc) w = {alu_reg, alu_data};
    else if (pop) w = load_q.pop_front();
    if (acc || pop) begin
      wr = 1;
`ifdef REGFILE_WB_ZERO_LOCK_EN
      wr = (w[ENT_W-1 -: ADDR_W] != 0);
`endif
      if (wr) begin
        exp_we = 1;
        exp_q.push_back(w);
      end
    end
    if (pop || was_empty) starve = 0;
    else if (acc && starve < STARVE_LIMIT) starve++;
    if (push) load_q.push_back({mem_reg, mem_data});
    alu_pend = alu_valid && !acc;
    mem_pend = mem_valid && !push;
  endtask

  task automatic check_outputs();
    logic [ENT_W-1:0] e;
    bit               f;
    f = (starve == STARVE_LIMIT) && (load_q.size() != 0);
    check("mem_pending", mem_pending, load_q.size());
    check("starve_force", starve_force, f);
    check("alu_ready", alu_ready, !f);
    check("mem_ready", mem_ready, load_q.size() < DEPTH);
    check("RegWrite", RegWrite, exp_we);
    if (exp_we && exp_q.size() > 0) begin
      e         = exp_q.pop_front();
      exp_wreg  = e[ENT_W-1 -: ADDR_W];
      exp_wdata = e[DATA_W-1:0];
    end
    check("WriteReg", WriteReg, exp_wreg);
    check("WriteData", WriteData, exp_wdata);
  endtask

  // Driver: called at a falling edge. Applies inputs, crosses one rising edge, then checks.
  task automatic drive(input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                       input logic mv, input logic [ADDR_W-1:0] mr, input logic [DATA_W-1:0] md);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // Random driver. It keeps a refused payload stable, as a real producer must.
  task automatic rand_step(input int alu_pct, input int mem_pct);
    logic              av, mv;
    logic [ADDR_W-1:0] ar, mr;
    logic [DATA_W-1:0] ad, md;
    if (alu_pend) begin
      av = 1'b1; ar = alu_reg; ad = alu_data;
    end else begin
      av = ($urandom_range(99) < alu_pct);
      ar = ADDR_W'($urandom); ad = DATA_W'($urandom);
    end
    if (mem_pend) begin
      mv = 1'b1; mr = mem_reg; md = mem_data;
    end else begin
      mv = ($urandom_range(99) < mem_pct);
      mr = ADDR_W'($urandom); md = DATA_W'($urandom);
    end
    drive(av, ar, ad, mv, mr, md);
  endtask

  initial begin
    reset_n   = 1'b0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset_n = 1'b1;

    // Single ALU write, then idle
    drive(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);

    // Load with an idle ALU
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'hBEEF);
    repeat (3) drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);

    // Writes to index 0 from both producers
    drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'h1234);
    repeat (3) drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);

    // Starvation: two loads queued behind continuous ALU traffic
    repeat (2) rand_step(100, 100);
    repeat (12) rand_step(100, 0);
    repeat (4) rand_step(0, 0);

    // FIFO full under continuous ALU traffic
    repeat (24) rand_step(100, 100);
    repeat (20) rand_step(100, 0);
    repeat (6) rand_step(0, 0);

    // Asynchronous reset mid-stream
    repeat (6) rand_step(100, 100);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_RegWrite", RegWrite, 1'b0);
    check("rst_mem_pending", mem_pending, 3'd0);
    check("rst_starve_force", starve_force, 1'b0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    reset_n = 1'b1;
    repeat (4) rand_step(0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_step(60, 50);
    end
    repeat (10) rand_step(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
